// File: rtl/channel_value_sched.sv
// channel_value_sched: round-robin collection of per-channel samples into a
// shadow buffer, copied once per frame (at vblank rise) into the active buffer
// that the drawing stages read. Displayed values therefore never change mid-frame.
module channel_value_sched #(
    parameter int unsigned NCH = 13,
    parameter int unsigned DW  = 12,
    parameter int unsigned IW  = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vblnk_in,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] data_in,
    output logic [NCH-1:0]    ack,
    input  logic [IW-1:0]     rd_idx,
    output logic [DW-1:0]     rd_data,
    output logic [NCH-1:0]    upd_mask,
    output logic              busy,
    output logic              frame_tick
);

    localparam logic [IW:0]   NCH_X = (IW+1)'(NCH);
    localparam logic [IW-1:0] LAST  = IW'(NCH - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_COPY    = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   k;
    logic [NCH-1:0]  pending;
    logic            vblnk_d;
    logic            vb_rise;

    logic [DW-1:0]   shadow [NCH];
    logic [DW-1:0]   active [NCH];
    logic [DW-1:0]   data_ch [NCH];

    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic [NCH-1:0]  grant_vec;
    logic [IW:0]     cand;

    // Split the flat data bus into per-channel samples
    for (genvar g = 0; g < NCH; g++) begin : g_split
        assign data_ch[g] = data_in[g*DW +: DW];
    end

    assign vb_rise = vblnk_in & ~vblnk_d;

    // Round-robin search from rr_ptr, skipping channels whose ack is high now
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        cand      = '0;
        if (state == S_COLLECT) begin
            for (int unsigned off = 0; off < NCH; off++) begin
                cand = {1'b0, rr_ptr} + (IW+1)'(off);
                if (cand >= NCH_X) begin
                    cand = cand - NCH_X;
                end
                if (!grant_vld && req[cand[IW-1:0]] && !ack[cand[IW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[IW-1:0];
                end
            end
        end
        if (grant_vld) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Frame FSM: collect grants, then copy shadow to active over NCH cycles
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= S_COLLECT;
            rr_ptr     <= '0;
            k          <= '0;
            pending    <= '0;
            ack        <= '0;
            upd_mask   <= '0;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
            vblnk_d    <= 1'b1;
        end else begin
            vblnk_d    <= vblnk_in;
            frame_tick <= 1'b0;
            case (state)
                S_COLLECT: begin
                    ack <= grant_vec;
                    if (grant_vld) begin
                        pending[grant_idx] <= 1'b1;
                        rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + IW'(1);
                    end
                    if (vb_rise) begin
                        state    <= S_COPY;
                        k        <= '0;
                        busy     <= 1'b1;
                        upd_mask <= pending | grant_vec;
                        pending  <= '0;
                    end
                end
                S_COPY: begin
                    ack <= '0;
                    if (k == LAST) begin
                        k          <= '0;
                        state      <= S_COLLECT;
                        busy       <= 1'b0;
                        frame_tick <= 1'b1;
                    end else begin
                        k <= k + IW'(1);
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    // Shadow buffer: written by the granted requester
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
            end
        end else if (grant_vld) begin
            shadow[grant_idx] <= data_ch[grant_idx];
        end
    end

    // Active buffer: one entry copied from shadow per COPY cycle
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                active[i] <= '0;
            end
        end else if (state == S_COPY) begin
            active[k] <= shadow[k];
        end
    end

    // Registered read port; out-of-range indices read as zero
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (32'(rd_idx) < NCH) begin
            rd_data <= active[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_channel_value_sched.sv
// Bench for channel_value_sched: directed scenarios with literal expectations
// plus randomized requesters, all outputs checked each cycle against a model.
module tb_channel_value_sched;

    localparam int NCH = 13;
    localparam int DW  = 12;
    localparam int IW  = 4;

    logic              pclk = 1'b0;
    logic              rst;
    logic              vblnk_in;
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] data_in;
    logic [IW-1:0]     rd_idx;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     rd_data;
    logic [NCH-1:0]    upd_mask;
    logic              busy;
    logic              frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    channel_value_sched #(.NCH(NCH), .DW(DW), .IW(IW)) dut (
        .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .req(req), .data_in(data_in),
        .ack(ack), .rd_idx(rd_idx), .rd_data(rd_data), .upd_mask(upd_mask),
        .busy(busy), .frame_tick(frame_tick)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the copy is a snapshot taken at vblank rise that becomes
    // visible one index per cycle; reads see old values for indices not yet copied.
    logic [DW-1:0]  m_shadow [NCH];
    logic [DW-1:0]  m_act    [NCH];
    logic [DW-1:0]  m_snap   [NCH];
    logic [NCH-1:0] m_pend, m_ack, m_upd;
    logic [DW-1:0]  m_rd;
    int             m_rr, m_age;
    bit             m_copy, m_busy, m_tick, m_vbd;

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = '0; m_act[i] = '0; m_snap[i] = '0;
        end
        m_pend = '0; m_ack = '0; m_upd = '0; m_rd = '0;
        m_rr = 0; m_age = 0; m_copy = 1'b0; m_busy = 1'b0; m_tick = 1'b0; m_vbd = 1'b1;
    endfunction

    always @(posedge pclk) begin : mdl
        int j, g, c;
        bit rise;
        logic [NCH-1:0] na;
        if (rst) begin
            m_reset();
        end else begin
            j = int'(rd_idx);
            if (j >= NCH)                 m_rd = '0;
            else if (m_copy && j < m_age) m_rd = m_snap[j];
            else                          m_rd = m_act[j];
            rise  = vblnk_in && !m_vbd;
            m_vbd = vblnk_in;
            m_tick = 1'b0;
            if (!m_copy) begin
                g = -1;
                for (int off = 0; off < NCH; off++) begin
                    c = (m_rr + off) % NCH;
                    if (g < 0 && req[c] && !m_ack[c]) g = c;
                end
                na = '0;
                if (g >= 0) begin
                    na[g] = 1'b1;
                    m_shadow[g] = data_in[g*DW +: DW];
                    m_pend[g] = 1'b1;
                    m_rr = (g + 1) % NCH;
                end
                m_ack = na;
                if (rise) begin
                    m_upd  = m_pend;
                    m_pend = '0;
                    m_copy = 1'b1;
                    m_age  = 0;
                    m_busy = 1'b1;
                    m_snap = m_shadow;
                end
            end else begin
                m_ack = '0;
                m_age++;
                if (m_age == NCH) begin
                    m_act  = m_snap;
                    m_copy = 1'b0;
                    m_busy = 1'b0;
                    m_tick = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge pclk) begin
        if (chk_en) begin
            chk("ack",        32'(ack),        32'(m_ack));
            chk("rd_data",    32'(rd_data),    32'(m_rd));
            chk("upd_mask",   32'(upd_mask),   32'(m_upd));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        end
    end

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic set_ch(input int i, input logic r, input logic [DW-1:0] d);
        req[i] = r;
        data_in[i*DW +: DW] = d;
    endtask

    task automatic wait_copy(input string nm, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk(nm, 32'(cnt), 32'd13);
    endtask

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cnt, nt, r;
        m_reset();
        rst = 1'b1; vblnk_in = 1'b1; req = '0; data_in = '0; rd_idx = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_ack",  32'(ack),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Idle with vblank held high: no copy, reads all zero
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        for (int j = 0; j < 16; j++) begin
            rd_idx = IW'(j);
            tick();
            chk("idle_rd", 32'(rd_data), 32'd0);
        end

        // Two writes then a frame copy
        set_ch(3, 1'b1, 12'h123);
        tick();
        chk("t2_ack3", 32'(ack), 32'h0008);
        set_ch(3, 1'b0, 12'h000);
        set_ch(7, 1'b1, 12'h7AB);
        tick();
        chk("t2_ack7", 32'(ack), 32'h0080);
        set_ch(7, 1'b0, 12'h000);
        tick();
        chk("t2_ack_idle", 32'(ack), 32'h0);
        vblnk_in = 1'b0; tick();
        vblnk_in = 1'b1; tick();
        wait_copy("t2_busy_len", cnt);
        chk("t2_tick", 32'(frame_tick), 32'd1);
        rd_idx = 4'd3; tick();
        chk("t2_rd3", 32'(rd_data), 32'h123);
        rd_idx = 4'd7; tick();
        chk("t2_rd7", 32'(rd_data), 32'h7AB);
        chk("t2_upd", 32'(upd_mask), 32'h0088);

        // All requesters held, pointer at 0 after reset
        rst = 1'b1; tick(); rst = 1'b0;
        req = '1; data_in = '0;
        for (int n = 0; n < 14; n++) begin
            tick();
            chk("t3_rr_order", 32'(ack), 32'(1) << (n % NCH));
        end
        req = '0;
        tick(); tick();

        // Request rising in the vblank-rise cycle is included in the copy
        vblnk_in = 1'b0; tick();
        vblnk_in = 1'b1;
        set_ch(5, 1'b1, 12'hABC);
        tick();
        chk("t4_ack5", 32'(ack), 32'h0020);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_upd",  32'(upd_mask), 32'h1FFF);
        set_ch(5, 1'b0, 12'h000);
        wait_copy("t4_busy_len", cnt);
        rd_idx = 4'd5; tick();
        chk("t4_rd5", 32'(rd_data), 32'hABC);

        // Second vblank rise during copy is ignored; request waits for COLLECT
        vblnk_in = 1'b0; tick();
        vblnk_in = 1'b1; tick();
        cnt = 0; nt = 0;
        for (int c = 1; c <= 40 && busy === 1'b1; c++) begin
            cnt++;
            if (c == 3) vblnk_in = 1'b0;
            if (c == 4) vblnk_in = 1'b1;
            if (c == 5) set_ch(2, 1'b1, 12'h222);
            tick();
            if (frame_tick === 1'b1) nt++;
        end
        chk("t5_busy_len", 32'(cnt), 32'd13);
        chk("t5_ticks",    32'(nt),  32'd1);
        tick();
        chk("t5_ack2", 32'(ack), 32'h0004);
        set_ch(2, 1'b0, 12'h000);
        repeat (3) tick();
        chk("t5_no_recopy", 32'(busy), 32'd0);

        // Reset mid-copy clears everything; next vblank copies fully
        vblnk_in = 1'b0; tick();
        vblnk_in = 1'b1; tick();
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_tick", 32'(frame_tick), 32'd0);
        for (int j = 0; j < 16; j++) begin
            rd_idx = IW'(j);
            tick();
            chk("t6_rd_zero", 32'(rd_data), 32'd0);
        end
        set_ch(9, 1'b1, 12'h999); tick();
        set_ch(9, 1'b0, 12'h000); tick();
        vblnk_in = 1'b0; tick();
        vblnk_in = 1'b1; tick();
        wait_copy("t6_busy_len", cnt);
        rd_idx = 4'd9; tick();
        chk("t6_rd9", 32'(rd_data), 32'h999);
        rd_idx = 4'd5; tick();
        chk("t6_rd5", 32'(rd_data), 32'h000);

        // Randomized requesters, vblank, reads and occasional reset
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (req[i]) begin
                    if (ack[i]) begin
                        r = int'($urandom_range(0, 2));
                        if (r == 0)      set_ch(i, 1'b0, DW'($urandom));
                        else if (r == 1) set_ch(i, 1'b1, DW'($urandom));
                    end
                end else if ($urandom_range(0, 4) == 0) begin
                    set_ch(i, 1'b1, DW'($urandom));
                end
            end
            if ($urandom_range(0, 29) == 0) vblnk_in = ~vblnk_in;
            rd_idx = IW'($urandom_range(0, 15));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
